// File: rtl/branch_compare_unit.sv
// Two-stage branch condition evaluator: S1 captures operands, S2 holds the
// registered flags/taken result; a saturating counter tallies consumed taken results.
module branch_compare_unit #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       Cond,
    input  logic [TAG_W-1:0] Tag,
    input  logic             Clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             Taken,
    output logic [7:0]       Flags,
    output logic             Illegal,
    output logic [TAG_W-1:0] TagOut,
    output logic [CNT_W-1:0] TakenCount
);

    // Handshake: a transfer happens on a rising edge where valid && ready; the
    // producer holds its payload stable while valid && !ready, and the consumer
    // may raise or drop ready freely (in_ready depends combinationally on out_ready).

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic [3:0]       r_s1_cond;
    logic [TAG_W-1:0] r_s1_tag;

    logic             r_s2_valid;
    logic             r_s2_taken;
    logic [7:0]       r_s2_flags;
    logic             r_s2_illegal;
    logic [TAG_W-1:0] r_s2_tag;
    logic [CNT_W-1:0] r_cnt;

    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_s2_load;
    logic             w_eq;
    logic             w_zero;
    logic             w_neg;
    logic             w_lt;
    logic             w_ltu;
    logic [7:0]       w_flags;
    logic             w_taken;

    assign in_ready   = !r_s1_valid || !r_s2_valid || out_ready;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_s2_valid && out_ready;
    assign w_s2_load  = r_s1_valid && (!r_s2_valid || out_ready);

    always_comb begin
        w_eq    = (r_s1_a == r_s1_b);
        w_zero  = (r_s1_a == '0);
        w_neg   = r_s1_a[WIDTH-1];
        w_lt    = ($signed(r_s1_a) < $signed(r_s1_b));
        w_ltu   = (r_s1_a < r_s1_b);
        w_flags = {w_ltu, w_lt, w_neg || w_zero, !w_neg, w_neg,
                   !w_neg && !w_zero, !w_eq, w_eq};
        // Reserved conditions (MSB set) never take, but flags are still reported.
        w_taken = r_s1_cond[3] ? 1'b0 : w_flags[r_s1_cond[2:0]];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_cond  <= '0;
            r_s1_tag   <= '0;
        end else begin
            if (w_in_fire) begin
                r_s1_valid <= 1'b1;
                r_s1_a     <= A;
                r_s1_b     <= B;
                r_s1_cond  <= Cond;
                r_s1_tag   <= Tag;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_s2_valid   <= 1'b0;
            r_s2_taken   <= 1'b0;
            r_s2_flags   <= '0;
            r_s2_illegal <= 1'b0;
            r_s2_tag     <= '0;
        end else begin
            if (w_s2_load) begin
                r_s2_valid   <= 1'b1;
                r_s2_taken   <= w_taken;
                r_s2_flags   <= w_flags;
                r_s2_illegal <= r_s1_cond[3];
                r_s2_tag     <= r_s1_tag;
            end else if (out_ready) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (Clear) begin
            r_cnt <= '0;
        end else if (w_out_fire && r_s2_taken && !(&r_cnt)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out_valid  = r_s2_valid;
    assign Taken      = r_s2_taken;
    assign Flags      = r_s2_flags;
    assign Illegal    = r_s2_illegal;
    assign TagOut     = r_s2_tag;
    assign TakenCount = r_cnt;

endmodule

// File: tb/tb_branch_compare_unit.sv
// Self-checking bench for branch_compare_unit: directed scenario tasks plus a
// negedge scoreboard monitor that checks ordering, hold stability, in_ready and TakenCount.
module tb_branch_compare_unit;

  localparam int W = 14;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] A;
  logic [31:0] B;
  logic [3:0]  Cond;
  logic [3:0]  Tag;
  logic        Clear;
  logic        out_valid;
  logic        out_ready;
  logic        Taken;
  logic [7:0]  Flags;
  logic        Illegal;
  logic [3:0]  TagOut;
  logic [1:0]  TakenCount;

  int n_cmp = 0;
  int n_err = 0;

  logic [W-1:0] exp_q[$];
  logic [1:0]   exp_cnt = 2'd0;
  logic         hold_prev = 1'b0;
  logic [W-1:0] prev_got = '0;
  logic         rand_done;

  branch_compare_unit #(.WIDTH(32), .TAG_W(4), .CNT_W(2)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cond(Cond), .Tag(Tag), .Clear(Clear),
    .out_valid(out_valid), .out_ready(out_ready), .Taken(Taken), .Flags(Flags),
    .Illegal(Illegal), .TagOut(TagOut), .TakenCount(TakenCount)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model: {taken, flags[7:0], illegal, tag}
  function automatic logic [W-1:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] c, input logic [3:0] t);
    logic eq, z, n, lt, ltu, tk;
    logic [7:0] f;
    eq  = (a == b);
    z   = (a == 32'd0);
    n   = a[31];
    ltu = (a < b);
    lt  = (a[31] != b[31]) ? a[31] : (a < b);
    f   = {ltu, lt, n | z, ~n, n, ~n & ~z, ~eq, eq};
    case (c)
      4'd0: tk = eq;
      4'd1: tk = ~eq;
      4'd2: tk = ~n & ~z;
      4'd3: tk = n;
      4'd4: tk = ~n;
      4'd5: tk = n | z;
      4'd6: tk = lt;
      4'd7: tk = ltu;
      default: tk = 1'b0;
    endcase
    return {tk, f, (c >= 4'd8), t};
  endfunction

  // scoreboard monitor: looks at settled values half a cycle before each edge
  always @(negedge clock) begin
    logic [W-1:0] got;
    logic [W-1:0] e;
    logic         exp_rdy;
    logic         pop_taken;
    if (reset_n) begin
      exp_rdy = (exp_q.size() < 2) || out_ready;
      n_cmp++;
      if (in_ready !== exp_rdy) begin
        n_err++;
        $display("FAIL in_ready: got %b expected %b (occupancy %0d)", in_ready, exp_rdy, exp_q.size());
      end
      n_cmp++;
      if (TakenCount !== exp_cnt) begin
        n_err++;
        $display("FAIL taken_count: got %0d expected %0d", TakenCount, exp_cnt);
      end
      got = {Taken, Flags, Illegal, TagOut};
      if (hold_prev) begin
        n_cmp++;
        if (got !== prev_got) begin
          n_err++;
          $display("FAIL hold_stable: got %h expected %h", got, prev_got);
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_got  = got;
      pop_taken = 1'b0;
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output: got %h expected nothing", got);
        end else begin
          e = exp_q.pop_front();
          pop_taken = e[W-1];
          if (got !== e) begin
            n_err++;
            $display("FAIL result: got %h expected %h", got, e);
          end
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(A, B, Cond, Tag));
      if (Clear) exp_cnt = 2'd0;
      else if (pop_taken && exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
    end
  end

  // driver tasks (called at posedge+1)
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] c, input logic [3:0] t);
    int   guard;
    logic acc;
    A = a; B = b; Cond = c; Tag = t; in_valid = 1'b1;
    guard = 0;
    acc = 1'b0;
    do begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock);
      #1;
      guard++;
    end while (!acc && guard < 200);
    n_cmp++;
    if (!acc) begin
      n_err++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 within 200 cycles");
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clock);
      #1;
      guard++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d pending expected 0", exp_q.size());
    end
  endtask

  task automatic run_vector(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                            input logic [3:0] t, input logic e_taken, input logic [7:0] e_flags,
                            input logic e_ill);
    drain();
    send(a, b, c, t);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL latency_early: out_valid got %b expected 0", out_valid);
    end
    @(posedge clock);
    #1;
    n_cmp++;
    if (out_valid !== 1'b1 || Taken !== e_taken || Flags !== e_flags ||
        Illegal !== e_ill || TagOut !== t) begin
      n_err++;
      $display("FAIL vector c=%0d: got v=%b t=%b f=%b i=%b tag=%0d expected v=1 t=%b f=%b i=%b tag=%0d",
               c, out_valid, Taken, Flags, Illegal, TagOut, e_taken, e_flags, e_ill, t);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; A = '0; B = '0; Cond = '0; Tag = '0;
    Clear = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || Taken !== 1'b0 || Flags !== 8'h00 || Illegal !== 1'b0 ||
        TagOut !== 4'h0 || TakenCount !== 2'd0) begin
      n_err++;
      $display("FAIL reset_values: got v=%b t=%b f=%h i=%b tag=%h cnt=%0d expected all 0",
               out_valid, Taken, Flags, Illegal, TagOut, TakenCount);
    end
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_flags();
    run_vector(32'd5,        32'd5,        4'd0, 4'd3, 1'b1, 8'h15, 1'b0);
    run_vector(32'hFFFFFFFF, 32'd1,        4'd6, 4'd4, 1'b1, 8'h6A, 1'b0);
    run_vector(32'hFFFFFFFF, 32'd1,        4'd7, 4'd5, 1'b0, 8'h6A, 1'b0);
    run_vector(32'd0,        32'd0,        4'd5, 4'd6, 1'b1, 8'h31, 1'b0);
    run_vector(32'd0,        32'd0,        4'd2, 4'd7, 1'b0, 8'h31, 1'b0);
    run_vector(32'd0,        32'd0,        4'd9, 4'd8, 1'b0, 8'h31, 1'b1);
    run_vector(32'd7,        32'd3,        4'd1, 4'd9, 1'b1, 8'h16, 1'b0);
    run_vector(32'd3,        32'd7,        4'd7, 4'hA, 1'b1, 8'hD6, 1'b0);
    run_vector(32'h80000000, 32'd0,        4'd3, 4'hB, 1'b1, 8'h6A, 1'b0);
    run_vector(32'h80000000, 32'd0,        4'd4, 4'hC, 1'b0, 8'h6A, 1'b0);
    run_vector(32'h80000000, 32'd0,        4'hF, 4'hD, 1'b0, 8'h6A, 1'b1);
  endtask

  task automatic test_back_to_back();
    drain();
    out_ready = 1'b0;
    A = 32'd1; B = 32'd1; Cond = 4'd0; Tag = 4'd0; in_valid = 1'b1;
    @(posedge clock);
    #1;
    Tag = 4'd1; A = 32'd2;
    @(posedge clock);
    #1;
    Tag = 4'd2; A = 32'd3;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || TagOut !== 4'd0) begin
        n_err++;
        $display("FAIL stall_cycle%0d: got in_ready=%b out_valid=%b tag=%0d expected 0/1/0",
                 i, in_ready, out_valid, TagOut);
      end
      if (i < 2) begin
        @(posedge clock);
        #1;
      end
    end
    out_ready = 1'b1;
    send(32'd3, 32'd1, 4'd0, 4'd2);
    send(32'd4, 32'd4, 4'd0, 4'd3);
    drain();
  endtask

  task automatic test_throughput();
    realtime t0;
    drain();
    t0 = $realtime;
    for (int i = 0; i < 8; i++) send(32'(i), 32'd4, 4'(i), 4'(i));
    n_cmp++;
    if ($realtime - t0 != 80.0) begin
      n_err++;
      $display("FAIL throughput: got %0t expected 80 time units for 8 accepts", $realtime - t0);
    end
    drain();
  endtask

  task automatic test_random();
    drain();
    rand_done = 1'b0;
    fork
      begin
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 40; i++) begin
          b = $urandom;
          case ($urandom_range(0, 3))
            0: a = 32'd0;
            1: a = b;
            2: a = $urandom;
            default: a = 32'h80000000;
          endcase
          send(a, b, 4'($urandom_range(0, 15)), 4'(i));
          repeat ($urandom_range(0, 1)) @(posedge clock);
          #0;
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clock);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    drain();
  endtask

  task automatic test_counter();
    drain();
    Clear = 1'b1;
    @(posedge clock);
    #1;
    Clear = 1'b0;
    n_cmp++;
    if (TakenCount !== 2'd0) begin
      n_err++;
      $display("FAIL clear: got %0d expected 0", TakenCount);
    end
    for (int i = 0; i < 5; i++) send(32'd9, 32'd9, 4'd0, 4'(i));
    drain();
    n_cmp++;
    if (TakenCount !== 2'd3) begin
      n_err++;
      $display("FAIL saturate: got %0d expected 3", TakenCount);
    end
    out_ready = 1'b0;
    send(32'd2, 32'd2, 4'd0, 4'd5);
    @(posedge clock);
    #1;
    Clear = 1'b1;
    out_ready = 1'b1;
    @(posedge clock);
    #1;
    Clear = 1'b0;
    n_cmp++;
    if (TakenCount !== 2'd0) begin
      n_err++;
      $display("FAIL clear_priority: got %0d expected 0", TakenCount);
    end
    drain();
  endtask

  task automatic test_reset_inflight();
    drain();
    send(32'd6, 32'd6, 4'd0, 4'd1);
    drain();
    n_cmp++;
    if (TakenCount !== 2'd1) begin
      n_err++;
      $display("FAIL count_before_reset: got %0d expected 1", TakenCount);
    end
    out_ready = 1'b0;
    send(32'd1, 32'd1, 4'd0, 4'd2);
    send(32'd1, 32'd1, 4'd0, 4'd3);
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_before_reset: got out_valid=%b in_ready=%b expected 1/0", out_valid, in_ready);
    end
    #1;
    reset_n = 1'b0;
    exp_q.delete();
    exp_cnt = 2'd0;
    hold_prev = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || TakenCount !== 2'd0 || Taken !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset: got out_valid=%b cnt=%0d taken=%b in_ready=%b expected 0/0/0/1",
               out_valid, TakenCount, Taken, in_ready);
    end
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL after_release: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
    run_vector(32'd5, 32'd5, 4'd0, 4'd3, 1'b1, 8'h15, 1'b0);
    drain();
  endtask

  initial begin
    test_reset();
    test_flags();
    test_back_to_back();
    test_throughput();
    test_random();
    test_counter();
    test_reset_inflight();
    repeat (2) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
